// File: rtl/pwm_pkg.sv
// ---------------------------------------------------------------------------
// pwm_pkg
// Shared types and constants for the PWM output stage.
//   pwm_state_t : controller state (IDLE / RUN)
//   PWM_BITS    : width of the PWM counter and duty values
//   DUTY_FULL   : duty code that means "constantly high"
//   NUM_CH      : number of user output channels
//   pwm_level() : PWM comparator shared by all channels
// ---------------------------------------------------------------------------
package pwm_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pwm_state_t;

    localparam int               PWM_BITS  = 8;
    localparam logic [PWM_BITS-1:0] DUTY_FULL = 8'hFF;
    localparam logic [PWM_BITS-1:0] CNT_LAST  = 8'hFF;
    localparam int               NUM_CH    = 16;

    // 0xFF is special-cased so that full duty never shows a low cycle;
    // otherwise the output is high while the counter is below the duty.
    function automatic logic pwm_level(input logic [PWM_BITS-1:0] cnt,
                                       input logic [PWM_BITS-1:0] duty);
        return (duty == DUTY_FULL) || (cnt < duty);
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// ---------------------------------------------------------------------------
// pwm_prescaler
// Divides the system clock into PWM count steps.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   clr   : synchronous clear, holds the count at zero
//   tick  : high for one cycle every CLK_DIV cycles while not cleared
// ---------------------------------------------------------------------------
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = 13
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int            PW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] cnt_q, cnt_d;
    logic          wrap;

    assign wrap = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || wrap) begin
            cnt_d = '0;
        end
    end

    // A cleared prescaler never ticks, so the PWM counter cannot advance
    // on the same edge that the controller leaves RUN.
    assign tick = wrap && !clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pwm_output_stage.sv
// ---------------------------------------------------------------------------
// pwm_output_stage
// Drives 16 user outputs from the SPI configuration bytes. Each channel is
// forced low, held high, or follows a shared 8-bit PWM waveform whose duty
// is taken from a shadow register updated only at period boundaries.
//   clk               : system clock
//   rst_n             : asynchronous active-low reset
//   en_reg_out_7_0    : output enable, channels 7..0
//   en_reg_out_15_8   : output enable, channels 15..8
//   en_reg_pwm_7_0    : PWM-mode select, channels 7..0
//   en_reg_pwm_15_8   : PWM-mode select, channels 15..8
//   pwm_duty_cycle    : requested duty (0x00 = 0 %, 0xFF = 100 %)
//   out               : registered channel outputs
//   period_start      : registered one-cycle pulse at each period boundary
// ---------------------------------------------------------------------------
module pwm_output_stage
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        en_reg_out_7_0,
    input  logic [7:0]        en_reg_out_15_8,
    input  logic [7:0]        en_reg_pwm_7_0,
    input  logic [7:0]        en_reg_pwm_15_8,
    input  logic [7:0]        pwm_duty_cycle,
    output logic [NUM_CH-1:0] out,
    output logic              period_start
);

    logic [NUM_CH-1:0]   en_out, en_pwm;
    logic                active;
    logic                tick;
    logic                presc_clr;
    logic                pwm_hi;

    pwm_state_t          state_q, state_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [PWM_BITS-1:0] duty_sh_q, duty_sh_d;
    logic                period_start_q, period_start_d;
    logic [NUM_CH-1:0]   out_q, out_d;

    assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    assign active = |(en_out & en_pwm);

    // The prescaler is held clear outside RUN, and also on the edge that
    // leaves RUN, so both counters restart from zero together.
    assign presc_clr = (state_q != RUN) || !active;

    pwm_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (presc_clr),
        .tick  (tick)
    );

    always_comb begin
        state_d        = state_q;
        pwm_cnt_d      = pwm_cnt_q;
        duty_sh_d      = duty_sh_q;
        period_start_d = 1'b0;
        case (state_q)
            IDLE: begin
                // Track the requested duty so the first period after entry
                // uses the latest value.
                pwm_cnt_d = '0;
                duty_sh_d = pwm_duty_cycle;
                if (active) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!active) begin
                    // Leaving RUN wins over a coincident wrap: no pulse.
                    state_d   = IDLE;
                    pwm_cnt_d = '0;
                end else if (tick) begin
                    pwm_cnt_d = pwm_cnt_q + 1'b1;
                    if (pwm_cnt_q == CNT_LAST) begin
                        duty_sh_d      = pwm_duty_cycle;
                        period_start_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                pwm_cnt_d = '0;
            end
        endcase
    end

    assign pwm_hi = pwm_level(pwm_cnt_q, duty_sh_q);
    assign out_d  = en_out & (~en_pwm | {NUM_CH{pwm_hi}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            pwm_cnt_q      <= '0;
            duty_sh_q      <= '0;
            period_start_q <= 1'b0;
            out_q          <= '0;
        end else begin
            state_q        <= state_d;
            pwm_cnt_q      <= pwm_cnt_d;
            duty_sh_q      <= duty_sh_d;
            period_start_q <= period_start_d;
            out_q          <= out_d;
        end
    end

    assign out          = out_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_output_stage.sv
module tb_pwm_output_stage;

    localparam int D = 2;
    localparam int P = 256 * D;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  en_reg_out_7_0, en_reg_out_15_8;
    logic [7:0]  en_reg_pwm_7_0, en_reg_pwm_15_8;
    logic [7:0]  pwm_duty_cycle;
    logic [15:0] dut_out;
    logic        dut_ps;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pwm_output_stage #(.CLK_DIV(D)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .out             (dut_out),
        .period_start    (dut_ps)
    );

    // Reference model: time elapsed since entering RUN determines the
    // position in the period; duty latches on entry and at each period end.
    int          m_t;
    logic        m_run;
    logic [7:0]  m_duty;
    logic [15:0] m_out;
    logic        m_ps;
    int          m_cnt;
    logic        m_hi;
    logic [15:0] m_eo, m_ep;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t = 0; m_run = 1'b0; m_duty = 8'h00; m_out = 16'h0; m_ps = 1'b0;
        end else begin
            m_eo  = {en_reg_out_15_8, en_reg_out_7_0};
            m_ep  = {en_reg_pwm_15_8, en_reg_pwm_7_0};
            m_cnt = m_run ? (m_t % P) / D : 0;
            m_hi  = (m_duty == 8'hFF) || (m_cnt < int'(m_duty));
            m_out = m_eo & (~m_ep | {16{m_hi}});
            m_ps  = 1'b0;
            if (!m_run) begin
                m_duty = pwm_duty_cycle;
                if ((m_eo & m_ep) != 16'h0) begin
                    m_run = 1'b1;
                    m_t   = 0;
                end
            end else if ((m_eo & m_ep) == 16'h0) begin
                m_run = 1'b0;
            end else begin
                m_t = m_t + 1;
                if (m_t % P == 0) begin
                    m_duty = pwm_duty_cycle;
                    m_ps   = 1'b1;
                end
            end
        end
    end

    task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
        en_reg_out_15_8 = eo[15:8];
        en_reg_out_7_0  = eo[7:0];
        en_reg_pwm_15_8 = ep[15:8];
        en_reg_pwm_7_0  = ep[7:0];
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_en(16'h0, 16'h0);
        pwm_duty_cycle = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if (dut_out !== 16'h0000) begin
            errors++; $display("FAIL reset_out got %h exp 0000", dut_out);
        end
        checks++;
        if (dut_ps !== 1'b0) begin
            errors++; $display("FAIL reset_ps got %b exp 0", dut_ps);
        end
        rst_n = 1'b1;
        @(negedge clk);
        set_en(16'h00FF, 16'h0000);
        @(negedge clk);
        checks++;
        if (dut_out !== 16'h00FF) begin
            errors++; $display("FAIL static_on got %h exp 00ff", dut_out);
        end
        set_en(16'h0000, 16'h0000);
        @(negedge clk);
        checks++;
        if (dut_out !== 16'h0000) begin
            errors++; $display("FAIL static_off got %h exp 0000", dut_out);
        end
    endtask

    task automatic test_duty50();
        bit got = 0;
        int hi = 0, pulses = 0, last_ps = -1;
        set_en(16'h0, 16'h0);
        pwm_duty_cycle = 8'h80;
        repeat (2) @(negedge clk);
        set_en(16'h0001, 16'h0001);
        for (int i = 0; i < 1200 && !got; i++) begin
            @(negedge clk);
            if (dut_ps === 1'b1) got = 1;
        end
        checks++;
        if (!got) begin
            errors++; $display("FAIL duty50_first_ps got none exp pulse within 1200");
        end
        for (int i = 0; i < P; i++) begin
            @(negedge clk);
            checks++;
            if (dut_out !== m_out || dut_ps !== m_ps) begin
                errors++;
                $display("FAIL duty50_model cyc %0d got %h/%b exp %h/%b", i, dut_out, dut_ps, m_out, m_ps);
            end
            if (dut_out[0] === 1'b1) hi++;
            if (dut_ps === 1'b1) begin pulses++; last_ps = i; end
        end
        checks++;
        if (hi != 256) begin
            errors++; $display("FAIL duty50_high got %0d exp 256", hi);
        end
        checks++;
        if (pulses != 1 || last_ps != P - 1) begin
            errors++; $display("FAIL duty50_ps_spacing got %0d pulses at %0d exp 1 at %0d", pulses, last_ps, P - 1);
        end
    endtask

    task automatic test_extremes();
        int hi = 0, lo = 0;
        set_en(16'h0, 16'h0);
        pwm_duty_cycle = 8'h00;
        repeat (2) @(negedge clk);
        set_en(16'h0001, 16'h0001);
        @(negedge clk);
        for (int i = 0; i < 3 * P; i++) begin
            @(negedge clk);
            if (dut_out[0] === 1'b1) hi++;
        end
        checks++;
        if (hi != 0) begin
            errors++; $display("FAIL duty00_high got %0d exp 0", hi);
        end
        set_en(16'h0, 16'h0);
        pwm_duty_cycle = 8'hFF;
        repeat (2) @(negedge clk);
        set_en(16'h0001, 16'h0001);
        @(negedge clk);
        for (int i = 0; i < 3 * P; i++) begin
            @(negedge clk);
            if (dut_out[0] !== 1'b1) lo++;
        end
        checks++;
        if (lo != 0) begin
            errors++; $display("FAIL dutyff_low got %0d exp 0", lo);
        end
    endtask

    task automatic test_glitch_free();
        bit got = 0;
        int hi = 0, last_ps = -1;
        set_en(16'h0, 16'h0);
        pwm_duty_cycle = 8'h80;
        repeat (2) @(negedge clk);
        set_en(16'h0001, 16'h0001);
        for (int i = 0; i < 1200 && !got; i++) begin
            @(negedge clk);
            if (dut_ps === 1'b1) got = 1;
        end
        checks++;
        if (!got) begin
            errors++; $display("FAIL glitch_first_ps got none exp pulse within 1200");
        end
        for (int i = 0; i < P; i++) begin
            @(negedge clk);
            if (dut_out[0] === 1'b1) hi++;
            if (dut_ps === 1'b1) last_ps = i;
            if (i == 80) pwm_duty_cycle = 8'h20;
        end
        checks++;
        if (hi != 256) begin
            errors++; $display("FAIL glitch_old_period_high got %0d exp 256", hi);
        end
        checks++;
        if (last_ps != P - 1) begin
            errors++; $display("FAIL glitch_ps_pos got %0d exp %0d", last_ps, P - 1);
        end
        hi = 0;
        for (int i = 0; i < P; i++) begin
            @(negedge clk);
            if (dut_out[0] === 1'b1) hi++;
            if (i == 0) begin
                checks++;
                if (dut_out[0] !== 1'b1) begin
                    errors++; $display("FAIL glitch_new_start got %b exp 1", dut_out[0]);
                end
            end
            if (i == 64) begin
                checks++;
                if (dut_out[0] !== 1'b0) begin
                    errors++; $display("FAIL glitch_new_end got %b exp 0", dut_out[0]);
                end
            end
        end
        checks++;
        if (hi != 64) begin
            errors++; $display("FAIL glitch_new_period_high got %0d exp 64", hi);
        end
    endtask

    task automatic test_mixed();
        int hi = 0, bad = 0, ps_seen = 0;
        set_en(16'h0, 16'h0);
        pwm_duty_cycle = 8'h40;
        repeat (2) @(negedge clk);
        set_en(16'hFFFF, 16'hAAAA);
        @(negedge clk);
        for (int i = 0; i < P; i++) begin
            @(negedge clk);
            if ((dut_out & 16'h5555) !== 16'h5555) bad++;
            if ((dut_out & 16'hAAAA) !== 16'h0000 && (dut_out & 16'hAAAA) !== 16'hAAAA) bad++;
            if (dut_out[1] === 1'b1) hi++;
            checks++;
            if (dut_out !== m_out) begin
                errors++; $display("FAIL mixed_model cyc %0d got %h exp %h", i, dut_out, m_out);
            end
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL mixed_pattern got %0d bad cycles exp 0", bad);
        end
        checks++;
        if (hi != 128) begin
            errors++; $display("FAIL mixed_high got %0d exp 128", hi);
        end
        set_en(16'hFFFF, 16'h0000);
        @(negedge clk);
        checks++;
        if (dut_out !== 16'hFFFF) begin
            errors++; $display("FAIL disable_pwm_out got %h exp ffff", dut_out);
        end
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (dut_ps !== 1'b0 || dut_out !== 16'hFFFF) ps_seen++;
        end
        checks++;
        if (ps_seen != 0) begin
            errors++; $display("FAIL disable_idle got %0d bad cycles exp 0", ps_seen);
        end
    endtask

    task automatic test_async_reset();
        bit got = 0;
        int hi = 0, first_hi = -1;
        set_en(16'h0, 16'h0);
        pwm_duty_cycle = 8'h80;
        repeat (2) @(negedge clk);
        set_en(16'h0001, 16'h0001);
        for (int i = 0; i < 1200 && !got; i++) begin
            @(negedge clk);
            if (dut_ps === 1'b1) got = 1;
        end
        checks++;
        if (!got) begin
            errors++; $display("FAIL areset_first_ps got none exp pulse within 1200");
        end
        repeat (200) @(negedge clk);
        checks++;
        if (dut_out[0] !== 1'b1) begin
            errors++; $display("FAIL areset_pre got %b exp 1", dut_out[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (dut_out !== 16'h0000 || dut_ps !== 1'b0) begin
            errors++; $display("FAIL areset_immediate got %h/%b exp 0000/0", dut_out, dut_ps);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < P; i++) begin
            @(negedge clk);
            if (dut_out[0] === 1'b1) begin
                hi++;
                if (first_hi < 0) first_hi = i;
            end
            checks++;
            if (dut_out !== m_out || dut_ps !== m_ps) begin
                errors++;
                $display("FAIL areset_model cyc %0d got %h/%b exp %h/%b", i, dut_out, dut_ps, m_out, m_ps);
            end
        end
        checks++;
        if (first_hi != 1 || hi != 256) begin
            errors++; $display("FAIL areset_restart got first %0d high %0d exp first 1 high 256", first_hi, hi);
        end
    endtask

    task automatic test_random();
        logic [15:0] eo, ep;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            checks++;
            if (dut_out !== m_out || dut_ps !== m_ps) begin
                errors++;
                $display("FAIL random_model cyc %0d got %h/%b exp %h/%b", i, dut_out, dut_ps, m_out, m_ps);
            end
            if ($urandom_range(0, 299) == 0) begin
                eo = 16'($urandom);
                ep = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
                set_en(eo, ep);
            end
            if ($urandom_range(0, 149) == 0) begin
                case ($urandom_range(0, 3))
                    0:       pwm_duty_cycle = 8'h00;
                    1:       pwm_duty_cycle = 8'hFF;
                    default: pwm_duty_cycle = 8'($urandom);
                endcase
            end
        end
    endtask

    initial begin
        test_reset();
        test_duty50();
        test_extremes();
        test_glitch_free();
        test_mixed();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_output_stage.md
# pwm_output_stage

Downstream consumer of the SPI register block: takes the five configuration bytes it produces (output enables, PWM-mode enables, duty cycle) and drives the 16 user outputs. Each output is forced low, held static high, or driven with a shared 8-bit PWM waveform. A shadow duty register updates only at period boundaries, so SPI writes never produce runt pulses.

## Interface
- `CLK_DIV`, default 13: clock cycles per PWM count step, minimum 1. At 10 MHz this gives 10e6/(256·13) ≈ 3.0 kHz.
- `clk`  in  1  system clock; single clock domain. All inputs are already synchronous to it.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en_reg_out_7_0`  in  8  output enable, channels 7..0.
- `en_reg_out_15_8`  in  8  output enable, channels 15..8.
- `en_reg_pwm_7_0`  in  8  PWM-mode select, channels 7..0.
- `en_reg_pwm_15_8`  in  8  PWM-mode select, channels 15..8.
- `pwm_duty_cycle`  in  8  requested duty; 0x00 = 0 %, 0xFF = 100 %.
- `out`  out  16  channel outputs, registered.
- `period_start`  out  1  one-cycle pulse at each PWM period boundary, registered.

## Operation
- Concatenation rules:
  - en_out = {en_reg_out_15_8, en_reg_out_7_0}
  - en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0}
- Per channel i, next out[i]:
  - en_out[i]=0 → 0.
  - en_out[i]=1, en_pwm[i]=0 → 1.
  - en_out[i]=1, en_pwm[i]=1 → pwm_hi.
- pwm_hi = (duty_sh == 0xFF) || (pwm_cnt < duty_sh). The comparison is unsigned 8-bit. 0xFF is a special case and gives a constant high.
- Internal state:
  - prescaler: 0..CLK_DIV-1, width max(1,$clog2(CLK_DIV)).
  - pwm_cnt: 8-bit.
  - duty_sh: 8-bit shadow duty register.
- The FSM has two states, IDLE and RUN. active = |(en_out & en_pwm).
  - IDLE: prescaler=0 and pwm_cnt=0 (held). duty_sh <= pwm_duty_cycle every cycle. period_start=0. Transition to RUN when active=1.
  - RUN: prescaler increments every cycle and wraps at CLK_DIV-1, producing tick. On tick, pwm_cnt increments with wrap 255→0. When pwm_cnt wraps on a tick, duty_sh <= pwm_duty_cycle and period_start pulses. Transition to IDLE when active=0; the counters clear on the same edge.
- On entry to RUN, the first period starts at pwm_cnt=0 using the duty_sh loaded in IDLE. No period_start pulse is generated on entry.
- In RUN, duty changes take effect at the next wrap only.
- Enable changes take effect immediately, one cycle later on `out`.
- Reset values: `out`=0x0000, `period_start`=0, state=IDLE, prescaler=0, pwm_cnt=0, duty_sh=0x00.

## Timing
- Output latency: an input change at edge n is visible on `out` after edge n+1.
- PWM period is 256·CLK_DIV cycles.
- High time per period is duty_sh·CLK_DIV cycles. Exception: 0xFF gives high for the full period.
- pwm_cnt holds each value for CLK_DIV cycles. CLK_DIV=1 means tick every cycle.
- `period_start` is high for exactly the one cycle after the edge at which pwm_cnt goes 255→0.
- Simultaneous events:
  - Duty write on the same edge as wrap: the new value is captured.
  - active drops on the same edge as wrap: IDLE wins and no pulse is generated.
- Reset mid-period: all state clears asynchronously and `out` drops to 0 immediately. After release, operation restarts from IDLE.

## Structure
- Shared package `pwm_pkg`:
  - pwm_state_t enum {IDLE, RUN}
  - PWM_BITS=8
  - DUTY_FULL=8'hFF
  - NUM_CH=16
- One sub-module, `pwm_prescaler`:
  - parameter CLK_DIV
  - ports: clk, rst_n, clr, tick
  - `clr` synchronously zeroes the count. It is driven by !RUN.
- The top level contains the FSM, pwm_cnt, duty_sh, per-channel mux and output flops, roughly 150–200 lines total.

## Test plan
- Reset and static modes (CLK_DIV=2). Hold rst_n=0 → `out`=0x0000.
  - Release, then set en_out=0x00FF, en_pwm=0x0000 → `out`=0x00FF one cycle later.
  - Then set en_out=0x0000 → `out`=0x0000 one cycle later.
- Duty 50 % (CLK_DIV=2). Set duty=0x80, en_out=en_pwm=0x0001.
  - `out[0]` high 256 cycles, low 256 cycles, repeating.
  - `period_start` pulses every 512 cycles.
- Extremes (CLK_DIV=2). duty=0x00 → `out[0]` constant 0. duty=0xFF → `out[0]` constant 1, no low cycle across 3 periods.
- Glitch-free update (CLK_DIV=2). While in RUN at pwm_cnt≈40, change duty 0x80→0x20.
  - The current period keeps 256 high cycles.
  - The next period has 64 high cycles, starting at the `period_start` pulse.
- Mixed channels and disable:
  - Set en_out=0xFFFF, en_pwm=0xAAAA, duty=0x40 → even channels constant 1, odd channels PWM in phase.
  - Then clear en_pwm → state IDLE, `out`=0xFFFF, `period_start` stays low.
- Async reset mid-period: assert rst_n low between clock edges at pwm_cnt=100.
  - `out`=0 without a clock edge.
  - After release, the first PWM high phase begins from pwm_cnt=0.
